// File: rtl/copro_alu_pipe.sv
// Coprocessor ALU with a fixed-latency compute pipeline and an in-order
// result FIFO. Issue is credit based: an op is accepted only while the number
// of in-flight plus buffered results is below Depth, so every op that leaves
// the pipeline always finds a free FIFO slot and the pipeline never stalls.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              synchronous kill of everything in flight or buffered
//   valid_i / ready_o    issue handshake (ready_o independent of valid_i)
//   registers_i          source operands (NrRgprPorts x XLEN)
//   opcode_i             operation, hartid_i / id_i / rd_i carried to result
//   valid_o / ready_i    result handshake
//   result_o, hartid_o, id_o, rd_o, we_o, err_o   head-of-FIFO result
//   count_o              in-flight plus buffered entries

package cvxif_instr_pkg;
  typedef enum logic [3:0] {
    ILLEGAL    = 4'b0000,
    NOP        = 4'b0001,
    ADD        = 4'b0010,
    DOUBLE_RS1 = 4'b0011,
    DOUBLE_RS2 = 4'b0100,
    ADD_MULTI  = 4'b0101,
    ADD_RS3_R4 = 4'b0110,
    ADD_RS3_R  = 4'b0111
  } opcode_t;
endpackage

module copro_alu_pipe #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned NrRgprPorts = 2,
  parameter int unsigned Latency     = 1,
  parameter int unsigned Depth       = 2,
  parameter type         hartid_t    = logic,
  parameter type         id_t        = logic,
  // Operand bundle: one XLEN-bit word per source register port.
  parameter type         registers_t = logic [NrRgprPorts-1:0][XLEN-1:0],
  localparam int unsigned CntW       = $clog2(Depth + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  registers_t               registers_i,
  input  cvxif_instr_pkg::opcode_t opcode_i,
  input  hartid_t                  hartid_i,
  input  id_t                      id_i,
  input  logic [4:0]               rd_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [XLEN-1:0]          result_o,
  output hartid_t                  hartid_o,
  output id_t                      id_o,
  output logic [4:0]               rd_o,
  output logic                     we_o,
  output logic                     err_o,
  output logic [CntW-1:0]          count_o
);
  import cvxif_instr_pkg::*;

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  typedef logic [PtrW-1:0] ptr_t;

  typedef struct packed {
    logic            err;
    logic            we;
    logic [4:0]      rd;
    id_t             id;
    hartid_t         hartid;
    logic [XLEN-1:0] result;
  } entry_t;

  // Circular pointer advance over a FIFO that need not be a power of two deep.
  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == PtrW'(Depth - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PtrW'(1);
    end
  endfunction

  logic [XLEN-1:0] rs1_s, rs2_s, rs3_s;
  entry_t          issue_ent_s;
  logic            issue_s;
  logic            pop_s;
  entry_t          wr_ent_s;
  logic            wr_vld_s;

  entry_t          mem_r [Depth];
  ptr_t            rd_ptr_r, wr_ptr_r;
  logic [CntW-1:0] fifo_cnt_r;
  logic [CntW-1:0] count_r;

  assign rs1_s = registers_i[0];
  assign rs2_s = registers_i[1];

  if (NrRgprPorts == 3) begin : g_rs3
    assign rs3_s = registers_i[2];
  end else begin : g_no_rs3
    assign rs3_s = '0;
  end

  // A flush cycle never accepts an issue, so ready_o already folds it in.
  assign ready_o = (count_r < CntW'(Depth)) && !flush_i;
  assign issue_s = valid_i && ready_o;
  assign valid_o = (fifo_cnt_r != '0);
  assign pop_s   = valid_o && ready_i && !flush_i;
  assign count_o = count_r;

  // Opcode decode and arithmetic for the op being issued this cycle.
  always_comb begin
    issue_ent_s        = '0;
    issue_ent_s.hartid = hartid_i;
    issue_ent_s.id     = id_i;
    issue_ent_s.rd     = rd_i;
    issue_ent_s.we     = 1'b1;
    issue_ent_s.err    = 1'b0;
    case (opcode_i)
      NOP: begin
        issue_ent_s.rd = 5'd0;
        issue_ent_s.we = 1'b0;
      end
      ADD, ADD_MULTI: issue_ent_s.result = rs1_s + rs2_s;
      DOUBLE_RS1:     issue_ent_s.result = rs1_s << 1;
      DOUBLE_RS2:     issue_ent_s.result = rs2_s << 1;
      ADD_RS3_R4:     issue_ent_s.result = rs1_s + rs2_s + rs3_s;
      ADD_RS3_R: begin
        issue_ent_s.result = rs1_s + rs2_s + rs3_s;
        issue_ent_s.rd     = 5'd10;
      end
      default: begin
        // Unknown op still consumes a slot and reports itself as an error.
        issue_ent_s.rd  = 5'd0;
        issue_ent_s.we  = 1'b0;
        issue_ent_s.err = 1'b1;
      end
    endcase
  end

  // Latency 1 writes the FIFO on the issue edge; longer latencies add
  // Latency-1 register stages in front of the FIFO.
  if (Latency == 1) begin : g_lat1
    assign wr_vld_s = issue_s;
    assign wr_ent_s = issue_ent_s;
  end else begin : g_pipe
    logic [Latency-2:0] vld_r;
    entry_t             ent_r [Latency-1];

    // Shift issued ops through the fixed-latency stages; flush drops them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_r <= '0;
        for (int i = 0; i < int'(Latency) - 1; i++) begin
          ent_r[i] <= '0;
        end
      end else if (flush_i) begin
        vld_r <= '0;
      end else begin
        vld_r[0] <= issue_s;
        ent_r[0] <= issue_ent_s;
        for (int i = 1; i < int'(Latency) - 1; i++) begin
          vld_r[i] <= vld_r[i-1];
          ent_r[i] <= ent_r[i-1];
        end
      end
    end

    assign wr_vld_s = vld_r[Latency-2];
    assign wr_ent_s = ent_r[Latency-2];
  end

  // Result FIFO storage and pointers; credits guarantee no overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      fifo_cnt_r <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (wr_vld_s) begin
        mem_r[wr_ptr_r] <= wr_ent_s;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({wr_vld_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CntW'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CntW'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Credit counter: everything issued and not yet popped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r <= '0;
    end else if (flush_i) begin
      count_r <= '0;
    end else begin
      case ({issue_s, pop_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry drives the outputs; it only moves on a pop, so it holds
  // stable under backpressure.
  assign result_o = mem_r[rd_ptr_r].result;
  assign hartid_o = mem_r[rd_ptr_r].hartid;
  assign id_o     = mem_r[rd_ptr_r].id;
  assign rd_o     = mem_r[rd_ptr_r].rd;
  assign we_o     = mem_r[rd_ptr_r].we;
  assign err_o    = mem_r[rd_ptr_r].err;

endmodule

// File: tb/tb_copro_alu_pipe.sv
// Self-checking bench for copro_alu_pipe: directed scenarios plus randomized
// traffic, all compared against a transaction-level queue model.
module tb_copro_alu_pipe;
  import cvxif_instr_pkg::*;

  localparam int XLEN = 32;
  localparam int NRP  = 3;
  localparam int LAT  = 3;
  localparam int DEP  = 2;
  localparam int CW   = $clog2(DEP + 1);

  typedef logic [NRP-1:0][XLEN-1:0] regs_t;
  typedef logic [3:0] hid_t;
  typedef logic [3:0] iid_t;

  typedef struct {
    logic [XLEN-1:0] result;
    hid_t            hartid;
    iid_t            id;
    logic [4:0]      rd;
    logic            we;
    logic            err;
    int              arrive;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            flush_i = 1'b0;
  logic            valid_i = 1'b0;
  logic            ready_o;
  regs_t           registers_i = '0;
  opcode_t         opcode_i = NOP;
  hid_t            hartid_i = '0;
  iid_t            id_i = '0;
  logic [4:0]      rd_i = '0;
  logic            valid_o;
  logic            ready_i = 1'b0;
  logic [XLEN-1:0] result_o;
  hid_t            hartid_o;
  iid_t            id_o;
  logic [4:0]      rd_o;
  logic            we_o;
  logic            err_o;
  logic [CW-1:0]   count_o;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  ent_t q[$];

  copro_alu_pipe #(
    .XLEN(XLEN), .NrRgprPorts(NRP), .Latency(LAT), .Depth(DEP),
    .hartid_t(hid_t), .id_t(iid_t), .registers_t(regs_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o), .registers_i(registers_i),
    .opcode_i(opcode_i), .hartid_i(hartid_i), .id_i(id_i), .rd_i(rd_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .hartid_o(hartid_o), .id_o(id_o), .rd_o(rd_o), .we_o(we_o),
    .err_o(err_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result straight from the opcode table.
  function automatic ent_t ref_op(input opcode_t op, input regs_t r, input hid_t h,
                                  input iid_t i, input logic [4:0] rd);
    ent_t e;
    e.hartid = h; e.id = i; e.rd = rd; e.we = 1'b1; e.err = 1'b0;
    e.result = '0; e.arrive = 0;
    case (op)
      NOP:            begin e.rd = 5'd0; e.we = 1'b0; end
      ADD, ADD_MULTI: e.result = r[0] + r[1];
      DOUBLE_RS1:     e.result = r[0] * 2;
      DOUBLE_RS2:     e.result = r[1] * 2;
      ADD_RS3_R4:     e.result = r[0] + r[1] + r[2];
      ADD_RS3_R:      begin e.result = r[0] + r[1] + r[2]; e.rd = 5'd10; end
      default:        begin e.rd = 5'd0; e.we = 1'b0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  function automatic bit model_valid();
    return (q.size() > 0) && (q[0].arrive <= cyc);
  endfunction

  task automatic compare_all();
    ent_t h;
    bit   ev;
    ev = model_valid();
    check("ready", ready_o, (q.size() < DEP) && !flush_i);
    check("count", count_o, q.size());
    check("valid", valid_o, ev);
    if (ev) begin
      h = q[0];
      check("result", result_o, h.result);
      check("hartid", hartid_o, h.hartid);
      check("id", id_o, h.id);
      check("rd", rd_o, h.rd);
      check("we", we_o, h.we);
      check("err", err_o, h.err);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", valid_o, 0);
    check("rst_result", result_o, 0);
    check("rst_hartid", hartid_o, 0);
    check("rst_id", id_o, 0);
    check("rst_rd", rd_o, 0);
    check("rst_we", we_o, 0);
    check("rst_err", err_o, 0);
    check("rst_count", count_o, 0);
    check("rst_ready", ready_o, 1);
  endtask

  // One clock: decide handshakes from the model, advance, then compare.
  task automatic cycle();
    bit   iss, pp;
    ent_t e;
    iss = valid_i && (q.size() < DEP) && !flush_i;
    pp  = model_valid() && ready_i && !flush_i;
    e   = ref_op(opcode_i, registers_i, hartid_i, id_i, rd_i);
    @(posedge clk);
    cyc++;
    if (flush_i) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (iss) begin
        e.arrive = cyc + LAT - 1;
        q.push_back(e);
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit v, input opcode_t op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] c,
                       input iid_t id, input logic [4:0] rd, input bit rdy, input bit fl);
    valid_i = v; opcode_i = op; registers_i = {c, b, a};
    hartid_i = id ^ 4'h5; id_i = id; rd_i = rd; ready_i = rdy; flush_i = fl;
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, NOP, '0, '0, '0, 4'd0, 5'd0, rdy, 1'b0);
  endtask

  // Bounded wait for a result; an expired bound is a failed comparison.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!valid_o && n < 10) begin
      cycle();
      n++;
    end
    check(tag, valid_o, 1);
  endtask

  initial begin
    logic [3:0] opr;

    // Reset held from time 0; ready_o stays high throughout.
    #7;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    compare_all();

    // ADD 5+7 -> 12, rd 3.
    drive(1'b1, ADD, 32'd5, 32'd7, 32'd0, 4'd1, 5'd3, 1'b1, 1'b0);
    cycle();
    idle(1'b1);
    wait_valid("add_arrive");
    check("add_result", result_o, 32'd12);
    check("add_rd", rd_o, 5'd3);
    cycle();

    // 32-bit wrap: 2 * 0x8000_0001.
    drive(1'b1, DOUBLE_RS1, 32'h8000_0001, 32'd0, 32'd0, 4'd2, 5'd7, 1'b1, 1'b0);
    cycle();
    idle(1'b1);
    wait_valid("wrap_arrive");
    check("wrap_result", result_o, 32'h0000_0002);
    repeat (3) cycle();

    // Backpressure: three back-to-back issues with ready_i low.
    drive(1'b1, ADD_RS3_R, 32'd1, 32'd2, 32'd3, 4'd3, 5'd1, 1'b0, 1'b0);
    cycle();
    drive(1'b1, DOUBLE_RS2, 32'd0, 32'd21, 32'd0, 4'd4, 5'd2, 1'b0, 1'b0);
    cycle();
    drive(1'b1, ADD_RS3_R4, 32'd10, 32'd20, 32'd30, 4'd5, 5'd9, 1'b0, 1'b0);
    check("bp_ready_full", ready_o, 0);
    check("bp_count_full", count_o, 2);
    repeat (4) cycle();
    ready_i = 1'b1;
    repeat (8) cycle();
    idle(1'b1);
    repeat (4) cycle();

    // Simultaneous issue and pop at count DEP-1.
    drive(1'b1, ADD, 32'd100, 32'd1, 32'd0, 4'd6, 5'd4, 1'b1, 1'b0);
    cycle();
    idle(1'b1);
    repeat (LAT - 1) cycle();
    check("sim_count_before", count_o, 1);
    drive(1'b1, ADD_MULTI, 32'd200, 32'd2, 32'd0, 4'd7, 5'd5, 1'b1, 1'b0);
    cycle();
    check("sim_count_after", count_o, 1);
    idle(1'b1);
    repeat (LAT + 1) cycle();

    // Unknown opcode with id 4.
    drive(1'b1, opcode_t'(4'd12), 32'd3, 32'd4, 32'd5, 4'd4, 5'd17, 1'b1, 1'b0);
    cycle();
    idle(1'b1);
    wait_valid("unk_arrive");
    check("unk_err", err_o, 1);
    check("unk_we", we_o, 0);
    check("unk_id", id_o, 4);
    repeat (3) cycle();

    // Flush with two entries buffered, concurrent with a request.
    drive(1'b1, ADD, 32'd1, 32'd1, 32'd0, 4'd8, 5'd1, 1'b0, 1'b0);
    repeat (2) cycle();
    idle(1'b0);
    repeat (LAT) cycle();
    check("fl_count_before", count_o, 2);
    drive(1'b1, ADD, 32'd9, 32'd9, 32'd0, 4'd9, 5'd2, 1'b1, 1'b1);
    cycle();
    check("fl_valid", valid_o, 0);
    check("fl_count", count_o, 0);
    idle(1'b1);
    repeat (LAT + 2) cycle();

    // Reset mid-pipeline: one buffered, one in flight.
    drive(1'b1, DOUBLE_RS1, 32'd33, 32'd0, 32'd0, 4'd10, 5'd6, 1'b0, 1'b0);
    repeat (2) cycle();
    idle(1'b0);
    cycle();
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs();
    q.delete();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    compare_all();
    idle(1'b1);
    repeat (LAT + 3) cycle();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      opr         = 4'($urandom_range(0, 15));
      valid_i     = ($urandom_range(0, 3) != 0);
      ready_i     = ($urandom_range(0, 2) != 0);
      flush_i     = ($urandom_range(0, 49) == 0);
      opcode_i    = (opr > 4'd9) ? opcode_t'(4'($urandom_range(1, 7))) : opcode_t'(opr);
      registers_i = {$urandom, $urandom, $urandom};
      hartid_i    = 4'($urandom);
      id_i        = 4'($urandom);
      rd_i        = 5'($urandom);
      cycle();
    end

    idle(1'b1);
    repeat (LAT + 4) cycle();
    check("drain_count", count_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
